axi_ram_slave: RTL

- Synthesizable AXI4 slave backed by a single-port on-chip RAM.
- Sits directly downstream of the AXI self-test master and stands in for the DDR SDRAM controller in simulation and FPGA bring-up, so the write-then-read-back test closes without external memory.
- Serves one INCR burst at a time, either a write or a read, and arbitrates between AW and AR with round-robin priority.
- Reports burst-length violations on `bresp`.

---
 rtl/axi_ram_slave_if.sv | 41 ++++
 rtl/axi_ram_slave.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between the self-test master and axi_ram_slave.
// Carries the AW, W, B, AR and R channels (no IDs, sizes or bursts types:
// the slave only serves INCR bursts of full-width beats).
//   master modport: drives valids, addresses, lengths, write data, readies.
//   slave modport : drives address readies, wready, B and R channels.
interface axi_ram_slave_if #(
  parameter int A_WIDTH = 26,
  parameter int D_WIDTH = 16
);
  logic               awvalid;
  logic               awready;
  logic [A_WIDTH-1:0] awaddr;
  logic [7:0]         awlen;
  logic               wvalid;
  logic               wready;
  logic               wlast;
  logic [D_WIDTH-1:0] wdata;
  logic               bvalid;
  logic               bready;
  logic [1:0]         bresp;
  logic               arvalid;
  logic               arready;
  logic [A_WIDTH-1:0] araddr;
  logic [7:0]         arlen;
  logic               rvalid;
  logic               rready;
  logic               rlast;
  logic [D_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
           arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rlast, rdata
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wlast, wdata, bready,
           arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rlast, rdata
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a single-port on-chip RAM. Serves one INCR burst at a
// time (write or read), arbitrating AW against AR with round-robin priority,
// and flags burst-length violations with SLVERR on bresp.
// Ports:
//   aclk   : clock, rising edge
//   areset : asynchronous active-high reset
//   axi    : AXI slave bundle (AW/W/B/AR/R channels)
// Word index = byte address [D_LEVEL +: M_WIDTH]; upper bits alias.
module axi_ram_slave #(
  parameter int A_WIDTH = 26,
  parameter int D_WIDTH = 16,
  parameter int D_LEVEL = 1,
  parameter int M_WIDTH = 12
) (
  input  logic           aclk,
  input  logic           areset,
  axi_ram_slave_if.slave axi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_RPRE  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic [2:0]         state;
  logic [M_WIDTH-1:0] idx;
  logic [M_WIDTH-1:0] idx_inc;
  logic [M_WIDTH-1:0] rd_idx;
  logic [7:0]         beat;
  logic [7:0]         len;
  logic               err;
  logic               over;
  logic               wprio;
  logic [D_WIDTH-1:0] rdata_q;
  logic [A_WIDTH-1:0] aw_addr;
  logic [A_WIDTH-1:0] ar_addr;
  logic               aw_hs;
  logic               ar_hs;
  logic               w_beat;
  logic               w_keep;
  logic               r_hs;
  logic               unused_addr;

  logic [D_WIDTH-1:0] mem [2**M_WIDTH];

  assign aw_addr = axi.awaddr;
  assign ar_addr = axi.araddr;
  // Only the word-index slice of each address is used.
  assign unused_addr = ^{aw_addr, ar_addr};

  // Address readies are combinational on the valids, and forced low while
  // reset is asserted so no handshake can be seen during reset.
  assign axi.awready = ~areset & (state == S_IDLE) & axi.awvalid &
                       (~axi.arvalid | wprio);
  assign axi.arready = ~areset & (state == S_IDLE) & axi.arvalid &
                       (~axi.awvalid | ~wprio);
  assign aw_hs = axi.awvalid & axi.awready;
  assign ar_hs = axi.arvalid & axi.arready;

  assign axi.wready = (state == S_WRITE);
  assign w_beat     = axi.wvalid & axi.wready;
  assign w_keep     = w_beat & ~over;

  assign axi.bvalid = (state == S_RESP);
  assign axi.bresp  = (axi.bvalid & err) ? 2'b10 : 2'b00;

  assign axi.rvalid = (state == S_READ);
  assign axi.rlast  = axi.rvalid & (beat == len);
  assign axi.rdata  = rdata_q;
  assign r_hs       = axi.rvalid & axi.rready;

  assign idx_inc = idx + M_WIDTH'(1);

  // Prefetch the next word as the current one is accepted so beats stream
  // with no bubbles; when stalled the same word is simply held.
  always_comb begin
    rd_idx = idx;
    if (r_hs) rd_idx = idx_inc;
  end

  always_ff @(posedge aclk) begin
    if (w_keep) mem[idx] <= axi.wdata;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata_q <= '0;
    end else if (state == S_RPRE || r_hs) begin
      rdata_q <= mem[rd_idx];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
      idx   <= '0;
      beat  <= '0;
      len   <= '0;
      err   <= 1'b0;
      over  <= 1'b0;
      wprio <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            idx   <= aw_addr[D_LEVEL +: M_WIDTH];
            len   <= axi.awlen;
            beat  <= '0;
            err   <= 1'b0;
            over  <= 1'b0;
            wprio <= ~wprio;
            state <= S_WRITE;
          end else if (ar_hs) begin
            idx   <= ar_addr[D_LEVEL +: M_WIDTH];
            len   <= axi.arlen;
            beat  <= '0;
            wprio <= ~wprio;
            state <= S_RPRE;
          end
        end
        S_WRITE: begin
          if (w_beat) begin
            // 'over' marks beat > len without needing a 9-bit counter, so a
            // 256-beat burst cannot wrap beat back into the writable range.
            if (over) begin
              err <= 1'b1;
            end else begin
              idx  <= idx_inc;
              beat <= beat + 8'd1;
              if (beat == len) over <= 1'b1;
            end
            if (axi.wlast) begin
              if (beat != len) err <= 1'b1;
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (axi.bready) state <= S_IDLE;
        end
        S_RPRE: begin
          state <= S_READ;
        end
        S_READ: begin
          if (r_hs) begin
            idx  <= idx_inc;
            beat <= beat + 8'd1;
            if (axi.rlast) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
